// File: rtl/okeyexpand_if.sv
// Request/status/read bundle between the round datapath controller and the
// AES-128 key-expansion engine.
interface okeyexpand_if;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;

   modport master (
      output start, key, rd_idx,
      input  busy, done, keys_valid, rd_key
   );

   modport slave (
      input  start, key, rd_idx,
      output busy, done, keys_valid, rd_key
   );
endinterface

// File: rtl/okeyexpand.sv
// AES-128 key expansion: one round key per clock into an 11-entry key file,
// read back by round index with one cycle of latency.

// Byte-substitution on a 32-bit word; dir = 0 forward S-box, dir = 1 inverse.
module osubword (
   input  logic        dir,
   input  logic [31:0] word,
   output logic [31:0] result
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] p;
      x = a;
      y = b;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] b);
      logic [7:0] s;
      logic [7:0] r;
      s = b;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
   endfunction

   always_comb begin
      result = '0;
      for (int i = 0; i < 4; i++) begin
         result[8*i +: 8] = dir ? inv_sbox(word[8*i +: 8]) : fwd_sbox(word[8*i +: 8]);
      end
   end
endmodule

module okeyexpand (
   input  logic         clk,
   input  logic         reset,
   okeyexpand_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t       state;
   logic [127:0] kf [0:10];
   logic [3:0]   r;
   logic [7:0]   rcon;

   logic [3:0]   prev_idx;
   logic [127:0] prev;
   logic [31:0]  rot;
   logic [31:0]  sub;
   logic [31:0]  t;
   logic [31:0]  n0, n1, n2, n3;

   // Combinational round step from kf[r-1]; rcon tracks r as a running xtime.
   always_comb begin
      prev_idx = r - 4'd1;
      prev     = kf[prev_idx];
      rot      = {prev[23:0], prev[31:24]};
      t        = sub ^ {rcon, 24'h000000};
      n0       = prev[127:96] ^ t;
      n1       = n0 ^ prev[95:64];
      n2       = n1 ^ prev[63:32];
      n3       = n2 ^ prev[31:0];
   end

   osubword u_subword (
      .dir    (1'b0),
      .word   (rot),
      .result (sub)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         r              <= 4'd0;
         rcon           <= 8'h00;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.keys_valid <= 1'b0;
         bus.rd_key     <= '0;
         for (int i = 0; i < 11; i++) kf[i] <= '0;
      end else begin
         bus.done   <= 1'b0;
         bus.rd_key <= (bus.rd_idx <= 4'd10) ? kf[bus.rd_idx] : '0;
         case (state)
            IDLE, READY: begin
               if (bus.start) begin
                  kf[0]          <= bus.key;
                  r              <= 4'd1;
                  rcon           <= 8'h01;
                  bus.keys_valid <= 1'b0;
                  bus.busy       <= 1'b1;
                  state          <= EXPAND;
               end
            end
            EXPAND: begin
               kf[r] <= {n0, n1, n2, n3};
               r     <= r + 4'd1;
               rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               if (r == 4'd10) begin
                  state          <= READY;
                  bus.busy       <= 1'b0;
                  bus.done       <= 1'b1;
                  bus.keys_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_okeyexpand.sv
// Randomised and directed bench for okeyexpand against a FIPS-197 style
// word-recurrence model with a generator-built S-box.
`timescale 1ns/1ps
module tb_okeyexpand;
   logic clk = 1'b0;
   logic reset = 1'b1;

   okeyexpand_if bus ();

   okeyexpand dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int total = 0;
   int bad = 0;
   int cmp_total = 0;
   int cmp_bad = 0;

   logic [7:0]   sbox [0:255];
   logic [7:0]   rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   logic [127:0] m_file [0:10];
   logic [127:0] m_sched [0:10];
   bit           m_active = 0;
   int           m_cnt = 0;
   logic         exp_busy = 1'b0;
   logic         exp_done = 1'b0;
   logic         exp_valid = 1'b0;
   logic [127:0] exp_rd = '0;

   function automatic logic [7:0] rot8(input logic [7:0] b, input int k);
      logic [15:0] tt;
      tt = {b, b} << k;
      return tt[15:8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic void expand_key(input logic [127:0] k, output logic [127:0] s [0:10]);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/4], 24'h0};
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Reference: full schedule computed at acceptance, revealed one entry per edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active  = 0;
         m_cnt     = 0;
         exp_busy  = 1'b0;
         exp_done  = 1'b0;
         exp_valid = 1'b0;
         exp_rd    = '0;
         for (int i = 0; i < 11; i++) m_file[i] = '0;
      end else begin
         exp_rd   = (bus.rd_idx <= 4'd10) ? m_file[bus.rd_idx] : '0;
         exp_done = 1'b0;
         if (m_active) begin
            m_cnt = m_cnt + 1;
            m_file[m_cnt] = m_sched[m_cnt];
            if (m_cnt == 10) begin
               m_active  = 0;
               exp_done  = 1'b1;
               exp_valid = 1'b1;
            end
         end else if (bus.start) begin
            expand_key(bus.key, m_sched);
            m_file[0] = bus.key;
            m_cnt     = 0;
            m_active  = 1;
            exp_valid = 1'b0;
         end
         exp_busy = m_active;
      end
   end

   always begin
      @(posedge clk);
      #1;
      cmp_total += 4;
      if (bus.busy !== exp_busy) begin
         cmp_bad++;
         $display("[TB] FAIL busy t=%0t got=%b want=%b", $time, bus.busy, exp_busy);
      end
      if (bus.done !== exp_done) begin
         cmp_bad++;
         $display("[TB] FAIL done t=%0t got=%b want=%b", $time, bus.done, exp_done);
      end
      if (bus.keys_valid !== exp_valid) begin
         cmp_bad++;
         $display("[TB] FAIL keys_valid t=%0t got=%b want=%b", $time, bus.keys_valid, exp_valid);
      end
      if (bus.rd_key !== exp_rd) begin
         cmp_bad++;
         $display("[TB] FAIL rd_key t=%0t got=%h want=%h", $time, bus.rd_key, exp_rd);
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse start with k, optionally poke a second start at poke_cycle, and
   // report the number of edges until done (bounded).
   task automatic applyStimulus(input logic [127:0] k, input int poke_cycle,
                                input logic [127:0] poke_key, output int cycles);
      bus.start = 1'b1;
      bus.key   = k;
      stepCycle();
      bus.start = 1'b0;
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < 20) begin
         if (cycles + 1 == poke_cycle) begin
            bus.start = 1'b1;
            bus.key   = poke_key;
         end
         stepCycle();
         bus.start = 1'b0;
         cycles++;
         if (bus.done !== 1'b1) checkOutput("valid_low_during_expand", {127'h0, bus.keys_valid}, 128'h0);
      end
      if (cycles >= 20) checkOutput("done_timeout", 128'(cycles), 128'd10);
   endtask

   task automatic readKey(input logic [3:0] idx, output logic [127:0] data);
      bus.rd_idx = idx;
      stepCycle();
      data = bus.rd_key;
   endtask

   logic [127:0] fips_s [0:10];
   logic [127:0] zero_s [0:10];
   logic [127:0] data;
   logic [127:0] rkey;
   int           cycles;

   initial begin
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] x;
      bus.start  = 1'b0;
      bus.key    = '0;
      bus.rd_idx = 4'd0;

      p = 8'h01;
      q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
         sbox[p] = x ^ 8'h63;
      end
      sbox[0] = 8'h63;

      expand_key(FIPS_KEY, fips_s);
      expand_key(128'h0, zero_s);
      checkOutput("model_fips_rk1", fips_s[1], 128'ha0fafe1788542cb123a339392a6c7605);
      checkOutput("model_fips_rk10", fips_s[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      checkOutput("model_zero_rk1", zero_s[1], 128'h62636363626363636263636362636363);
      checkOutput("model_zero_rk10", zero_s[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      repeat (2) stepCycle();
      checkOutput("reset_busy", {127'h0, bus.busy}, 128'h0);
      checkOutput("reset_done", {127'h0, bus.done}, 128'h0);
      checkOutput("reset_valid", {127'h0, bus.keys_valid}, 128'h0);
      checkOutput("reset_rd_key", bus.rd_key, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      stepCycle();

      applyStimulus(FIPS_KEY, 0, '0, cycles);
      checkOutput("fips_latency", 128'(cycles), 128'd10);
      readKey(4'd1, data);  checkOutput("fips_rd1", data, 128'ha0fafe1788542cb123a339392a6c7605);
      readKey(4'd10, data); checkOutput("fips_rd10", data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      readKey(4'd0, data);  checkOutput("fips_rd0", data, FIPS_KEY);

      bus.rd_idx = 4'd10;
      for (int i = 9; i >= -1; i--) begin
         stepCycle();
         rkey = bus.rd_key;
         checkOutput("sweep", rkey, fips_s[i+1]);
         bus.rd_idx = (i >= 0) ? 4'(i) : 4'd15;
      end
      stepCycle();
      checkOutput("rd_idx15", bus.rd_key, 128'h0);

      applyStimulus(128'h0, 0, '0, cycles);
      checkOutput("zero_latency", 128'(cycles), 128'd10);
      readKey(4'd1, data);  checkOutput("zero_rd1", data, 128'h62636363626363636263636362636363);
      readKey(4'd10, data); checkOutput("zero_rd10", data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      applyStimulus(FIPS_KEY, 4, 128'h0, cycles);
      checkOutput("poke_latency", 128'(cycles), 128'd10);
      readKey(4'd1, data);  checkOutput("poke_rd1", data, 128'ha0fafe1788542cb123a339392a6c7605);
      readKey(4'd10, data); checkOutput("poke_rd10", data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, '0, cycles);
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 0, '0, cycles);
      checkOutput("back_to_back_latency", 128'(cycles), 128'd10);

      bus.start = 1'b1;
      bus.key   = {$urandom, $urandom, $urandom, $urandom};
      stepCycle();
      bus.start = 1'b0;
      repeat (6) stepCycle();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_busy", {127'h0, bus.busy}, 128'h0);
      checkOutput("async_done", {127'h0, bus.done}, 128'h0);
      checkOutput("async_valid", {127'h0, bus.keys_valid}, 128'h0);
      checkOutput("async_rd_key", bus.rd_key, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      stepCycle();
      applyStimulus(FIPS_KEY, 0, '0, cycles);
      checkOutput("after_reset_latency", 128'(cycles), 128'd10);
      readKey(4'd10, data); checkOutput("after_reset_rd10", data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      for (int c = 0; c < 600; c++) begin
         bus.rd_idx = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) begin
            bus.start = 1'b1;
            bus.key   = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            bus.start = 1'b0;
         end
         stepCycle();
      end
      bus.start = 1'b0;
      repeat (2) stepCycle();

      total = total + cmp_total;
      bad   = bad + cmp_bad;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
